bar_port_arbiter: RTL and testbench
===================================

BAR_PORT_ARBITER -- requirements
Module: bar_port_arbiter

Interface
REQ-001 The block SHALL take parameter WIDTH, default 64, as the SRAM bar data width in bits.
REQ-002 The block SHALL take parameter RD_LAT, default 1, range 1..4, as the bar read latency in cycles from address to bar_data_out.
REQ-003 The block SHALL take parameter MAX_LOCK, default 16, as the maximum number of consecutive locked grant cycles before a forced release.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port req, input, 4 bits: per-requester access request; index 0 = linear, 1 = qkmm, 2 = softmax, 3 = attmm.
REQ-007 The block SHALL have port lock, input, 4 bits: per-requester burst hold; keeps the grant while req is also high.
REQ-008 The block SHALL have port we, input, 4 bits: per-requester write enable (1 = write, 0 = read).
REQ-009 The block SHALL have port addr, input, 4x32 bits packed: per-requester address; requester i occupies bits [32i+31:32i].
REQ-010 The block SHALL have port wdata, input, 4xWIDTH bits packed: per-requester write data; requester i occupies bits [WIDTH*i+WIDTH-1:WIDTH*i].
REQ-011 The block SHALL have port gnt, output, 4 bits: one-hot-or-zero grant; the access is issued in the same cycle as the grant.
REQ-012 The block SHALL have port rvalid, output, 4 bits: per-requester read-data-valid strobe.
REQ-013 The block SHALL have port rdata, output, WIDTH bits: bar_data_out broadcast to all requesters.
REQ-014 The block SHALL have port bar_write_en, output, 1 bit: SRAM write enable.
REQ-015 The block SHALL have port bar_addr, output, 32 bits: SRAM address.
REQ-016 The block SHALL have port bar_data_in, output, WIDTH bits: SRAM write data.
REQ-017 The block SHALL have port bar_data_out, input, WIDTH bits: SRAM read data.

Function
REQ-018 gnt SHALL be computed combinationally from req, the registered owner/lock state and the registered round-robin pointer ptr (2 bits).
REQ-019 When no lock is held, the block SHALL grant the first requester with req=1 searching from ptr upward, modulo 4.
REQ-020 When no requester has req=1, gnt SHALL be 0000, bar_write_en 0, and bar_addr and bar_data_in 0.
REQ-021 When requester i is granted without holding a lock, ptr SHALL become (i+1) mod 4 at the next edge.
REQ-022 When a granted requester i has lock[i]=1, the block SHALL record i as the lock owner; while req[i] and lock[i] stay high, gnt SHALL remain on i regardless of other requests.
REQ-023 The lock SHALL release in the cycle the owner drops req or lock; that cycle re-arbitrates normally, and ptr SHALL become owner+1.
REQ-024 The block SHALL count the owner's consecutive granted cycles; when the count reaches MAX_LOCK, the lock SHALL release, ptr SHALL become owner+1, and the owner SHALL be ineligible for lock for exactly 1 cycle.
REQ-025 The bar outputs SHALL be a combinational mux of the granted requester's we, addr and wdata; bar_write_en SHALL equal we[granted].
REQ-026 A granted read (we=0) SHALL assert rvalid[i] for exactly 1 cycle, exactly RD_LAT cycles after the grant cycle, via an RD_LAT-deep registered pipeline of {valid, id}.
REQ-027 Back-to-back reads from any mix of requesters SHALL each produce their own rvalid in issue order; throughput SHALL be 1 access per cycle.
REQ-028 Granted writes SHALL produce no rvalid.
REQ-029 rdata SHALL always equal bar_data_out, without registering.
REQ-030 At most one bit of gnt and at most one bit of rvalid SHALL be high in any cycle.

Reset
REQ-031 While rst_n=0, ptr SHALL be 0, the lock owner SHALL be none, the lock counter SHALL be 0, the read pipeline SHALL be empty, and rvalid SHALL be 0000.
REQ-032 Asserting reset mid-burst SHALL discard in-flight reads: no rvalid SHALL appear after reset deasserts for reads issued before it.
REQ-033 gnt and the bar outputs SHALL follow REQ-018 to REQ-020 during reset, with ptr=0 and no lock.

Verification
REQ-034 Directed scenario: after reset, req=1111 held with lock=0000 for 8 cycles -> gnt SHALL be 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000.
REQ-035 Directed scenario: requester 1 issues a read at addr 0x40 with RD_LAT=1 -> bar_addr=0x40 in the grant cycle, and rvalid=0010 one cycle later with rdata equal to the SRAM word.
REQ-036 Directed scenario: req=0101 with lock[0]=1 held for 20 cycles (MAX_LOCK=16) -> gnt=0001 for 16 cycles, then 0100 for 1 cycle, then round-robin resumes.
REQ-037 Directed scenario: write from requester 3 (we[3]=1, addr 0x10, wdata 0xA5) in the same cycle requester 2 requests, with ptr=3 -> gnt=1000, bar_write_en=1, no rvalid; requester 2 is granted in the next cycle.
REQ-038 Directed scenario: rst_n pulsed low for 1 cycle right after a read grant with RD_LAT=2 -> rvalid stays 0000 and the next grant after reset goes to the lowest-index requester with req=1.

Source files
------------

// File: rtl/bar_port_arbiter.sv
// bar_port_arbiter
//   Arbitrates four engines (0 linear, 1 qkmm, 2 softmax, 3 attmm) onto one
//   SRAM bar port. Round-robin grant with optional burst lock, a forced
//   release after MAX_LOCK consecutive locked cycles, and a registered read
//   return pipeline that steers bar_data_out's valid strobe back to the
//   requester that issued the read.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req[3:0]            per-requester access request
//   lock[3:0]           per-requester burst hold (effective only with req)
//   we[3:0]             per-requester write enable (1 write, 0 read)
//   addr[4*32-1:0]      per-requester address, requester i at [32i+31:32i]
//   wdata[4*WIDTH-1:0]  per-requester write data, requester i at slice i
//   gnt[3:0]            one-hot-or-zero grant, access issued same cycle
//   rvalid[3:0]         read data valid, RD_LAT cycles after a read grant
//   rdata               bar_data_out broadcast, unregistered
//   bar_write_en        SRAM write enable
//   bar_addr            SRAM address
//   bar_data_in         SRAM write data
//   bar_data_out        SRAM read data
module bar_port_arbiter #(
    parameter int WIDTH    = 64,
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req,
    input  logic [3:0]           lock,
    input  logic [3:0]           we,
    input  logic [4*32-1:0]      addr,
    input  logic [4*WIDTH-1:0]   wdata,
    output logic [3:0]           gnt,
    output logic [3:0]           rvalid,
    output logic [WIDTH-1:0]     rdata,
    output logic                 bar_write_en,
    output logic [31:0]          bar_addr,
    output logic [WIDTH-1:0]     bar_data_in,
    input  logic [WIDTH-1:0]     bar_data_out
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

    typedef enum logic {
        ST_FREE,
        ST_LOCKED
    } lock_state_t;

    lock_state_t      state;
    lock_state_t      state_next;
    logic [1:0]       owner;
    logic [1:0]       owner_next;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] lock_cnt_next;
    logic [1:0]       ptr;
    logic [1:0]       ptr_next;
    logic             cool_valid;
    logic             cool_valid_next;
    logic [1:0]       cool_id;
    logic [1:0]       cool_id_next;

    // Grant decode
    logic             held;
    logic             any_gnt;
    logic [1:0]       gid;
    logic             rr_found;
    logic [1:0]       rr_id;
    logic [1:0]       idx;

    // Lock bookkeeping
    logic             eligible;
    logic             acquire;
    logic [CNT_W-1:0] hold_cnt;

    // Read return pipeline
    logic [RD_LAT-1:0] pipe_valid;
    logic [1:0]        pipe_id [RD_LAT];
    logic              read_issue;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_FREE;
            owner      <= '0;
            lock_cnt   <= '0;
            ptr        <= '0;
            cool_valid <= 1'b0;
            cool_id    <= '0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            lock_cnt   <= lock_cnt_next;
            ptr        <= ptr_next;
            cool_valid <= cool_valid_next;
            cool_id    <= cool_id_next;
        end
    end

    // ------------------------------------------------------------------
    // Output logic: grant selection and bar mux
    // ------------------------------------------------------------------
    always_comb begin
        held     = (state == ST_LOCKED) && req[owner] && lock[owner];
        rr_found = 1'b0;
        rr_id    = '0;
        idx      = '0;
        // First requester at or above ptr, wrapping modulo 4
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!rr_found && req[idx]) begin
                rr_found = 1'b1;
                rr_id    = idx;
            end
        end
        if (held) begin
            any_gnt = 1'b1;
            gid     = owner;
        end else begin
            any_gnt = rr_found;
            gid     = rr_id;
        end
    end

    always_comb begin
        gnt          = '0;
        bar_write_en = 1'b0;
        bar_addr     = '0;
        bar_data_in  = '0;
        if (any_gnt) begin
            gnt          = 4'b0001 << gid;
            bar_write_en = we[gid];
            bar_addr     = addr[32*gid +: 32];
            bar_data_in  = wdata[WIDTH*gid +: WIDTH];
        end
    end

    assign rdata = bar_data_out;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = ST_FREE;
        owner_next      = owner;
        lock_cnt_next   = '0;
        ptr_next        = ptr;
        cool_valid_next = 1'b0;
        cool_id_next    = cool_id;

        // ptr follows every grant; while locked this keeps it at owner+1,
        // so a release cycle re-arbitrates starting just past the owner.
        if (any_gnt) begin
            ptr_next = gid + 2'd1;
        end

        eligible = !(cool_valid && (cool_id == gid));
        acquire  = !held && any_gnt && lock[gid] && eligible;
        hold_cnt = held ? (lock_cnt + CNT_W'(1)) : CNT_W'(1);

        if (held || acquire) begin
            if (hold_cnt >= CNT_MAX) begin
                // Forced release: owner sits out lock acquisition next cycle
                state_next      = ST_FREE;
                lock_cnt_next   = '0;
                cool_valid_next = 1'b1;
                cool_id_next    = gid;
            end else begin
                state_next    = ST_LOCKED;
                owner_next    = gid;
                lock_cnt_next = hold_cnt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read return pipeline: {valid, id} delayed RD_LAT cycles
    // ------------------------------------------------------------------
    assign read_issue = any_gnt && !we[gid];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= '0;
            for (int unsigned s = 0; s < RD_LAT; s++) begin
                pipe_id[s] <= '0;
            end
        end else begin
            pipe_valid[0] <= read_issue;
            pipe_id[0]    <= gid;
            for (int unsigned s = 1; s < RD_LAT; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                pipe_id[s]    <= pipe_id[s-1];
            end
        end
    end

    always_comb begin
        rvalid = '0;
        if (pipe_valid[RD_LAT-1]) begin
            rvalid = 4'b0001 << pipe_id[RD_LAT-1];
        end
    end

endmodule

// File: tb/tb_bar_port_arbiter.sv
// tb_bar_port_arbiter
//   Drives two arbiter instances (RD_LAT=1 and RD_LAT=2) with identical
//   stimulus and compares both against a cycle-level reference model of the
//   arbitration, lock and read-return rules. A small SRAM stand-in per
//   instance returns an address-derived word after the instance's latency.
module tb_bar_port_arbiter;

    localparam int WIDTH    = 64;
    localparam int MAX_LOCK = 16;
    localparam int HIST     = 1024;

    logic                 clk;
    logic                 rst_n;
    logic [3:0]           req;
    logic [3:0]           lock;
    logic [3:0]           we;
    logic [4*32-1:0]      addr;
    logic [4*WIDTH-1:0]   wdata;

    logic [3:0]           gnt1, gnt2;
    logic [3:0]           rvalid1, rvalid2;
    logic [WIDTH-1:0]     rdata1, rdata2;
    logic                 bwe1, bwe2;
    logic [31:0]          baddr1, baddr2;
    logic [WIDTH-1:0]     bdin1, bdin2;
    logic [WIDTH-1:0]     bdout1, bdout2, bdout2_a;

    bar_port_arbiter #(.WIDTH(WIDTH), .RD_LAT(1), .MAX_LOCK(MAX_LOCK)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt1), .rvalid(rvalid1),
        .rdata(rdata1), .bar_write_en(bwe1), .bar_addr(baddr1),
        .bar_data_in(bdin1), .bar_data_out(bdout1)
    );

    bar_port_arbiter #(.WIDTH(WIDTH), .RD_LAT(2), .MAX_LOCK(MAX_LOCK)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt2), .rvalid(rvalid2),
        .rdata(rdata2), .bar_write_en(bwe2), .bar_addr(baddr2),
        .bar_data_in(bdin2), .bar_data_out(bdout2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] sram_word(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    // SRAM stand-ins with the matching read latency
    always @(posedge clk) begin
        bdout1   <= sram_word(baddr1);
        bdout2_a <= sram_word(baddr2);
        bdout2   <= bdout2_a;
    end

    int passed;
    int total;
    int cyc;

    // Reference model state
    int m_ptr;
    int m_owner;   // -1 = no lock held
    int m_run;     // consecutive locked grants of the owner
    int m_cool;    // requester barred from locking this cycle, -1 = none
    int sched1 [HIST];
    int sched2 [HIST];
    logic [63:0] word1 [HIST];
    logic [63:0] word2 [HIST];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock cycle: apply inputs, check, advance model. want >= 0 adds a
    // directed check of gnt against a hand-derived constant.
    task automatic step(input logic r_n, input logic [3:0] rq, input logic [3:0] lk,
                        input logic [3:0] w, input logic [127:0] a,
                        input logic [255:0] wd, input int want);
        int g;
        bit held;
        bit locked;
        int nc;
        logic [3:0]  e_gnt;
        logic        e_we;
        logic [31:0] e_addr;
        logic [63:0] e_din;
        logic [3:0]  e_rv1, e_rv2;

        rst_n = r_n;
        req   = rq;
        lock  = lk;
        we    = w;
        addr  = a;
        wdata = wd;

        if (!r_n) begin
            m_ptr   = 0;
            m_owner = -1;
            m_run   = 0;
            m_cool  = -1;
            for (int k = 0; k <= 4; k++) begin
                sched1[cyc+k] = -1;
                sched2[cyc+k] = -1;
            end
        end

        held = (m_owner >= 0) && rq[m_owner] && lk[m_owner];
        g = -1;
        if (held) g = m_owner;
        else begin
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && rq[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            end
        end

        e_gnt = '0; e_we = 1'b0; e_addr = '0; e_din = '0;
        if (g >= 0) begin
            e_gnt  = 4'b0001 << g;
            e_we   = w[g];
            e_addr = a[32*g +: 32];
            e_din  = wd[64*g +: 64];
        end
        e_rv1 = (sched1[cyc] >= 0) ? (4'b0001 << sched1[cyc]) : 4'b0000;
        e_rv2 = (sched2[cyc] >= 0) ? (4'b0001 << sched2[cyc]) : 4'b0000;

        #2;
        chk("gnt1", 64'(gnt1), 64'(e_gnt));
        chk("gnt2", 64'(gnt2), 64'(e_gnt));
        chk("bar_write_en1", 64'(bwe1), 64'(e_we));
        chk("bar_write_en2", 64'(bwe2), 64'(e_we));
        chk("bar_addr1", 64'(baddr1), 64'(e_addr));
        chk("bar_addr2", 64'(baddr2), 64'(e_addr));
        chk("bar_data_in1", bdin1, e_din);
        chk("bar_data_in2", bdin2, e_din);
        chk("rvalid1", 64'(rvalid1), 64'(e_rv1));
        chk("rvalid2", 64'(rvalid2), 64'(e_rv2));
        chk("rdata1_passthru", rdata1, bdout1);
        chk("rdata2_passthru", rdata2, bdout2);
        if (sched1[cyc] >= 0) chk("rdata1_word", rdata1, word1[cyc]);
        if (sched2[cyc] >= 0) chk("rdata2_word", rdata2, word2[cyc]);
        if (want >= 0) chk("gnt_directed", 64'(gnt1), 64'(want));

        if (r_n) begin
            if (g >= 0) m_ptr = (g + 1) % 4;
            locked = 0;
            if (held) begin
                m_run++;
                locked = 1;
            end else if (g >= 0 && lk[g] && m_cool != g) begin
                m_run  = 1;
                locked = 1;
            end
            nc = -1;
            if (locked) begin
                if (m_run >= MAX_LOCK) begin
                    m_owner = -1;
                    m_run   = 0;
                    nc      = g;
                end else m_owner = g;
            end else begin
                m_owner = -1;
                m_run   = 0;
            end
            m_cool = nc;
            if (g >= 0 && !w[g]) begin
                sched1[cyc+1] = g;
                word1[cyc+1]  = sram_word(a[32*g +: 32]);
                sched2[cyc+2] = g;
                word2[cyc+2]  = sram_word(a[32*g +: 32]);
            end
        end

        cyc++;
        @(negedge clk);
    endtask

    function automatic logic [127:0] rand_addr();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [255:0] rand_wdata();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        logic [127:0] a;
        logic [255:0] wd;
        logic [3:0]   rq, lk, w;
        int           own;
        int           exp_seq [8];

        passed = 0;
        total  = 0;
        cyc    = 0;
        for (int k = 0; k < HIST; k++) begin
            sched1[k] = -1;
            sched2[k] = -1;
            word1[k]  = '0;
            word2[k]  = '0;
        end
        m_ptr = 0; m_owner = -1; m_run = 0; m_cool = -1;
        rst_n = 1'b0; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        @(negedge clk);

        // Reset state, idle and with requests present during reset
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, '0, '0, 0);
        step(1'b0, 4'b1100, 4'b1100, 4'b0000, rand_addr(), rand_wdata(), 4);
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, '0, '0, 0);

        // All four requesting, no lock: plain rotation from requester 0
        exp_seq = '{1, 2, 4, 8, 1, 2, 4, 8};
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 4'b1111, 4'b0000, 4'b0000, rand_addr(), rand_wdata(), exp_seq[k]);
        end
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, '0, '0, 0);

        // Requester 1 reads 0x40
        a = '0;
        a[63:32] = 32'h0000_0040;
        step(1'b1, 4'b0010, 4'b0000, 4'b0000, a, '0, 2);
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, '0, '0, 0);
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, '0, '0, 0);

        // Park ptr at 0, then requester 0 holds a lock against requester 2
        step(1'b1, 4'b1000, 4'b0000, 4'b1000, rand_addr(), rand_wdata(), 8);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 4'b0101, 4'b0001, 4'b0000, rand_addr(), rand_wdata(),
                 (k == 16) ? 4 : 1);
        end
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, '0, '0, 0);

        // ptr=3, requester 3 writes 0xA5 at 0x10 while requester 2 waits
        step(1'b1, 4'b0100, 4'b0000, 4'b0100, rand_addr(), rand_wdata(), 4);
        a = '0;  a[127:96] = 32'h0000_0010;
        wd = '0; wd[255:192] = 64'hA5;
        step(1'b1, 4'b1100, 4'b0000, 4'b1000, a, wd, 8);
        step(1'b1, 4'b0100, 4'b0000, 4'b0000, rand_addr(), rand_wdata(), 4);
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, '0, '0, 0);

        // Read grant, one-cycle reset pulse, then lowest-index requester wins
        step(1'b1, 4'b0100, 4'b0000, 4'b0000, rand_addr(), rand_wdata(), 4);
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, '0, '0, 0);
        step(1'b1, 4'b1010, 4'b0000, 4'b1010, rand_addr(), rand_wdata(), 2);
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, '0, '0, 0);
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, '0, '0, 0);

        // Random traffic with occasional resets
        for (int k = 0; k < 300; k++) begin
            rq = 4'($urandom);
            lk = 4'($urandom & $urandom);
            w  = 4'($urandom);
            step(($urandom_range(0, 63) != 0), rq, lk, w, rand_addr(), rand_wdata(), -1);
        end

        // Long random bursts that reach the forced release
        for (int b = 0; b < 4; b++) begin
            own = $urandom_range(0, 3);
            for (int k = 0; k < 22; k++) begin
                rq = 4'($urandom);
                lk = 4'($urandom);
                rq[own] = 1'b1;
                lk[own] = 1'b1;
                w  = 4'($urandom);
                step(1'b1, rq, lk, w, rand_addr(), rand_wdata(), -1);
            end
        end

        for (int k = 0; k < 4; k++) begin
            step(1'b1, 4'b0000, 4'b0000, 4'b0000, '0, '0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
